dm_launch_ctrl: RTL

- Host-side sequencer directly upstream of the TopLevel core.
- Streams operand bytes into the core's data memory and pulses Start to launch the core program.
- Waits for Ack, then reads result bytes back from data memory and presents them on an output stream.
- Replaces bench-side preloading of operands and readback of results with synthesizable logic.

---
 rtl/dm_launch_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/dm_launch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_launch_ctrl
//  Description : Host-side job sequencer sitting in front of the TopLevel
//                core. It streams operand bytes into the core's data memory,
//                pulses Start to launch the core program, waits for Ack and
//                then reads the result bytes back out of data memory onto a
//                valid/ready output stream. A missing Ack is reported through
//                a sticky Error flag that only Reset clears.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk        in   1   clock, all state updates on the rising edge
//    Reset      in   1   synchronous active-high reset
//    InValid    in   1   operand byte valid
//    InReady    out  1   operand byte accepted this cycle (when InValid)
//    InData     in   DW  operand byte
//    DmWrEn     out  1   data-memory write enable
//    DmAddr     out  AW  data-memory address, shared by writes and reads
//    DmDataOut  out  DW  data-memory write data
//    DmDataIn   in   DW  data-memory read data (combinational on DmAddr)
//    Start      out  1   core launch request
//    Ack        in   1   core done flag
//    OutValid   out  1   result byte valid
//    OutReady   in   1   consumer accepts result byte
//    OutData    out  DW  result byte
//    Busy       out  1   a job is in progress
//    Error      out  1   sticky Ack-timeout flag
// ============================================================================
module dm_launch_ctrl #(
    parameter int AW           = 8,     // data-memory address width
    parameter int DW           = 8,     // data width
    parameter int BASE_ADDR    = 1,     // first DM address for operand bytes
    parameter int NUM_IN       = 4,     // operand bytes per job (1..255)
    parameter int RES_ADDR     = 5,     // first DM address of results
    parameter int NUM_OUT      = 4,     // result bytes per job (1..255)
    parameter int START_CYCLES = 2,     // cycles Start is held high (>=1)
    parameter int TIMEOUT      = 1024   // RUN cycles allowed before error
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          InValid,
    output logic          InReady,
    input  logic [DW-1:0] InData,
    output logic          DmWrEn,
    output logic [AW-1:0] DmAddr,
    output logic [DW-1:0] DmDataOut,
    input  logic [DW-1:0] DmDataIn,
    output logic          Start,
    input  logic          Ack,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [DW-1:0] OutData,
    output logic          Busy,
    output logic          Error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The timer must be able to hold TIMEOUT-1 without wrapping; one extra
    // bit keeps the compare safe for exact powers of two.
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [7:0]    C_IN_LAST    = 8'(NUM_IN - 1);
    localparam logic [7:0]    C_OUT_LAST   = 8'(NUM_OUT - 1);
    localparam logic [7:0]    C_START_LAST = 8'(START_CYCLES - 1);
    localparam logic [TW-1:0] C_TMR_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] C_TMR_ONE    = TW'(1);
    localparam logic [AW-1:0] C_BASE       = AW'(BASE_ADDR);
    localparam logic [AW-1:0] C_RES        = AW'(RES_ADDR);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,    // accepting operand bytes into DM
        S_LAUNCH = 3'd1,    // holding Start high
        S_RUN    = 3'd2,    // waiting for Ack, timer running
        S_DRAIN  = 3'd3,    // streaming result bytes out of DM
        S_ERR    = 3'd4     // Ack timeout, parked until Reset
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_cnt;           // byte index in LOAD/DRAIN, cycle count in LAUNCH
    logic [7:0]    w_cnt_nxt;
    logic [TW-1:0] r_tmr;           // RUN cycles elapsed
    logic [TW-1:0] w_tmr_nxt;

    logic [AW-1:0] w_cnt_addr;      // r_cnt resized to the address width
    logic          w_in_hs;         // operand byte handshake this cycle
    logic          w_out_hs;        // result byte handshake this cycle

    // Address arithmetic is done in AW bits so it wraps modulo 2^AW.
    assign w_cnt_addr = AW'(r_cnt);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_LOAD;
            r_cnt   <= 8'd0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    //
    // The handshake-type outputs (InReady, DmWrEn, Start, OutValid) are
    // masked by Reset so that an abort takes effect in the very cycle Reset
    // is raised: no DM write and no result byte can slip through while the
    // state register is still waiting for the reset edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmr_nxt   = r_tmr;

        InReady     = 1'b0;
        DmWrEn      = 1'b0;
        DmAddr      = '0;
        DmDataOut   = '0;
        Start       = 1'b0;
        OutValid    = 1'b0;
        OutData     = '0;
        Busy        = 1'b0;
        Error       = 1'b0;
        w_in_hs     = 1'b0;
        w_out_hs    = 1'b0;

        case (r_state)
            S_LOAD: begin
                InReady   = ~Reset;
                w_in_hs   = InValid & ~Reset;
                DmWrEn    = w_in_hs;
                DmAddr    = C_BASE + w_cnt_addr;
                DmDataOut = InData;
                // Idle only until the first operand byte of a job lands.
                Busy      = (r_cnt != 8'd0);
                if (w_in_hs) begin
                    if (r_cnt == C_IN_LAST) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = S_LAUNCH;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end
            end

            S_LAUNCH: begin
                // Ack is deliberately not looked at here: the core may still
                // be presenting the done flag from the previous job.
                Start = ~Reset;
                Busy  = 1'b1;
                if (r_cnt == C_START_LAST) begin
                    w_cnt_nxt   = 8'd0;
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end

            S_RUN: begin
                Busy      = 1'b1;
                w_tmr_nxt = r_tmr + C_TMR_ONE;
                // A late Ack that coincides with the last allowed cycle still
                // counts as success.
                if (Ack) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_DRAIN;
                end else if (r_tmr == C_TMR_LAST) begin
                    w_state_nxt = S_ERR;
                end
            end

            S_DRAIN: begin
                // DM is not written during DRAIN, so the combinational read
                // data stays put while the consumer stalls.
                Busy     = 1'b1;
                DmAddr   = C_RES + w_cnt_addr;
                OutValid = ~Reset;
                OutData  = DmDataIn;
                w_out_hs = OutValid & OutReady;
                if (w_out_hs) begin
                    if (r_cnt == C_OUT_LAST) begin
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end
            end

            S_ERR: begin
                Error = 1'b1;
            end

            default: begin
                w_state_nxt = S_LOAD;
                w_cnt_nxt   = 8'd0;
                w_tmr_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
